// File: rtl/matvec_mn.sv
// matvec_mn: streaming signed matrix-vector multiplier with persistent matrix storage and valid/ready handshakes.
module matvec_mn #(
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int WIDTH = 14,
  parameter int PIPE  = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               input_valid,
  output logic                               input_ready,
  input  logic [WIDTH-1:0]                   input_data,
  input  logic                               new_matrix,
  output logic                               output_valid,
  input  logic                               output_ready,
  output logic [2*WIDTH+$clog2(N)-1:0]       output_data
);
  localparam int OUT_W = 2*WIDTH + $clog2(N);
  localparam int PW    = 2*WIDTH;
  localparam int WA    = (M*N > 1) ? $clog2(M*N) : 1;
  localparam int XA    = (N > 1) ? $clog2(N) : 1;
  localparam int IA    = $clog2(N+1);
  localparam int RA    = (M > 1) ? $clog2(M) : 1;
  typedef enum logic [1:0] {LOAD_W, LOAD_X, COMPUTE, OUTPUT} state_t;
  state_t state, state_nxt;
  logic first;
  logic [WA-1:0] wcnt, w_idx;
  logic [XA-1:0] xcnt;
  logic [IA-1:0] icnt;
  logic [RA-1:0] row;
  logic signed [WIDTH-1:0] w_mem [M*N];
  logic signed [WIDTH-1:0] x_mem [N];
  logic signed [PW-1:0] pd [PIPE+1];
  logic [PIPE:0] pv, pf, pl;
  logic signed [OUT_W-1:0] acc;
  logic acc_done, in_fire, out_fire, issue, eff_w, w_last, x_last, row_last;
  assign input_ready  = (state == LOAD_W) || (state == LOAD_X);
  assign output_valid = state == OUTPUT;
  assign in_fire      = input_valid && input_ready && !reset;
  assign out_fire     = output_valid && output_ready;
  // the first beat of a problem sits in LOAD_W and is steered by new_matrix
  assign eff_w        = first ? new_matrix : (state == LOAD_W);
  assign issue        = (state == COMPUTE) && (icnt < IA'(N));
  assign w_last       = wcnt == WA'(M*N-1);
  assign x_last       = xcnt == XA'(N-1);
  assign row_last     = row == RA'(M-1);
  assign w_idx        = WA'(row) * WA'(N) + WA'(icnt[XA-1:0]);
  always_comb begin
    state_nxt = state;
    if (in_fire)
      state_nxt = eff_w ? (w_last ? LOAD_X : LOAD_W) : (x_last ? COMPUTE : LOAD_X);
    else if (acc_done)
      state_nxt = OUTPUT;
    else if (out_fire)
      state_nxt = row_last ? LOAD_W : COMPUTE;
  end
  always_ff @(posedge clk)
    state <= reset ? LOAD_W : state_nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      first       <= 1'b1;
      wcnt        <= '0;
      xcnt        <= '0;
      icnt        <= '0;
      row         <= '0;
      pv          <= '0;
      acc         <= '0;
      acc_done    <= 1'b0;
      output_data <= '0;
    end else begin
      first <= in_fire ? 1'b0 : (out_fire && row_last) ? 1'b1 : first;
      if (in_fire && eff_w) wcnt <= w_last ? '0 : wcnt + 1'b1;
      if (in_fire && !eff_w) xcnt <= x_last ? '0 : xcnt + 1'b1;
      icnt <= issue ? icnt + 1'b1 : out_fire ? '0 : icnt;
      if (out_fire) row <= row_last ? '0 : row + 1'b1;
      pv[0] <= issue;
      for (int i = 1; i <= PIPE; i++) pv[i] <= pv[i-1];
      if (pv[PIPE]) acc <= pf[PIPE] ? OUT_W'(pd[PIPE]) : acc + OUT_W'(pd[PIPE]);
      acc_done <= pv[PIPE] && pl[PIPE];
      if (acc_done) output_data <= acc;
    end
  end
  // storage and product pipeline data carry no reset; the matrix survives reset
  always_ff @(posedge clk) begin
    if (in_fire && eff_w) w_mem[wcnt] <= input_data;
    if (in_fire && !eff_w) x_mem[xcnt] <= input_data;
    pd[0] <= PW'(w_mem[w_idx]) * PW'(x_mem[icnt[XA-1:0]]);
    pf[0] <= icnt == '0;
    pl[0] <= icnt == IA'(N-1);
    for (int i = 1; i <= PIPE; i++) begin
      pd[i] <= pd[i-1];
      pf[i] <= pf[i-1];
      pl[i] <= pl[i-1];
    end
  end
endmodule

// File: tb/tb_matvec_mn.sv
// tb_matvec_mn: randomized self-checking bench for matvec_mn against a plain-arithmetic matrix-vector model.
module tb_matvec_mn;
  localparam int M = 4, N = 4, WIDTH = 14, PIPE = 2;
  localparam int OUT_W = 2*WIDTH + $clog2(N);
  localparam int LAT = N + PIPE + 2;
  logic clk = 0, reset = 1, input_valid = 0, new_matrix = 0, output_ready = 1;
  logic input_ready, output_valid;
  logic [WIDTH-1:0] input_data = '0;
  logic [OUT_W-1:0] output_data;
  int errors = 0, checks = 0, cyc = 0;
  logic signed [WIDTH-1:0] w_in [M*N];
  logic signed [WIDTH-1:0] x_in [N];
  logic signed [WIDTH-1:0] w_model [M*N];

  matvec_mn #(.M(M), .N(N), .WIDTH(WIDTH), .PIPE(PIPE)) dut (
    .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(input_ready),
    .input_data(input_data), .new_matrix(new_matrix), .output_valid(output_valid),
    .output_ready(output_ready), .output_data(output_data));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic nm, input bit gaps);
    int n = 0;
    while (gaps && $urandom_range(0, 2) == 0) begin
      input_valid = 0;
      input_data  = WIDTH'($urandom);
      new_matrix  = 1'($urandom);
      tick();
    end
    input_valid = 1;
    input_data  = d;
    new_matrix  = nm;
    while (!input_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (input_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: input_ready=%0b required 1", input_ready);
    end
    tick();
    input_valid = 0;
  endtask

  task automatic run_problem(input bit nm, input bit gaps, input int hold_row);
    int t0, prev, rise, prev_rise, n;
    longint e;
    logic signed [OUT_W-1:0] expv, held;
    if (nm)
      for (int i = 0; i < M*N; i++) begin
        send(w_in[i], (i == 0) ? 1'b1 : 1'($urandom), gaps);
        w_model[i] = w_in[i];
      end
    for (int i = 0; i < N; i++) send(x_in[i], (i == 0 && !nm) ? 1'b0 : 1'($urandom), gaps);
    t0 = cyc;
    checks++;
    if (input_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_drop: input_ready=%0b required 0", input_ready);
    end
    prev = t0;
    prev_rise = 0;
    for (int r = 0; r < M; r++) begin
      output_ready = (r != hold_row);
      n = 0;
      while (!output_valid && n < 100) begin
        tick();
        n++;
      end
      rise = cyc;
      e = 0;
      for (int k = 0; k < N; k++) e += longint'(w_model[r*N+k]) * longint'(x_in[k]);
      expv = OUT_W'(e);
      checks++;
      if (output_valid !== 1'b1 || rise != prev + LAT) begin
        errors++;
        $display("FAIL latency row %0d: valid=%0b after %0d cycles, required %0d", r, output_valid, rise - prev, LAT);
      end
      checks++;
      if (output_data !== expv) begin
        errors++;
        $display("FAIL data row %0d: got %0d required %0d", r, $signed(output_data), expv);
      end
      if (r > 0 && r - 1 != hold_row) begin
        checks++;
        if (rise - prev_rise != LAT + 1) begin
          errors++;
          $display("FAIL spacing row %0d: got %0d required %0d", r, rise - prev_rise, LAT + 1);
        end
      end
      if (r == hold_row) begin
        held = output_data;
        for (int i = 0; i < 10; i++) begin
          tick();
          checks++;
          if (output_valid !== 1'b1 || output_data !== held) begin
            errors++;
            $display("FAIL hold row %0d: valid=%0b data=%0d required valid=1 data=%0d", r, output_valid, $signed(output_data), held);
          end
        end
        output_ready = 1;
      end
      tick();
      prev = cyc;
      prev_rise = rise;
      checks++;
      if (output_valid !== 1'b0) begin
        errors++;
        $display("FAIL valid_drop row %0d: valid=%0b required 0", r, output_valid);
      end
    end
    checks++;
    if (input_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_return: input_ready=%0b required 1", input_ready);
    end
    output_ready = 1;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (input_ready !== 1'b1 || output_valid !== 1'b0 || output_data !== '0) begin
      errors++;
      $display("FAIL %s: ready=%0b valid=%0b data=%0d required 1 0 0", name, input_ready, output_valid, output_data);
    end
  endtask

  task automatic randomize_all();
    for (int i = 0; i < M*N; i++) w_in[i] = WIDTH'($urandom);
    for (int i = 0; i < N; i++) x_in[i] = WIDTH'($urandom);
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    check_idle("reset_state");
  endtask

  task automatic test_identity();
    for (int i = 0; i < M*N; i++) w_in[i] = (i / N == i % N) ? 14'sd1 : 14'sd0;
    for (int i = 0; i < N; i++) x_in[i] = WIDTH'(i + 1);
    run_problem(1, 0, -1);
  endtask

  task automatic test_reuse();
    x_in = '{-14'sd1, 14'sd5, 14'sd0, 14'sd7};
    run_problem(0, 0, -1);
  endtask

  task automatic test_extreme();
    for (int i = 0; i < M*N; i++) w_in[i] = -14'sd8192;
    for (int i = 0; i < N; i++) x_in[i] = -14'sd8192;
    run_problem(1, 0, -1);
  endtask

  task automatic test_backpressure();
    randomize_all();
    run_problem(1, 0, 1);
  endtask

  task automatic test_random_gaps();
    randomize_all();
    run_problem(1, 1, -1);
    run_problem(1, 0, -1);
    run_problem(0, 1, -1);
  endtask

  task automatic test_reset_abort();
    randomize_all();
    for (int i = 0; i < 7; i++) send(WIDTH'($urandom), (i == 0) ? 1'b1 : 1'($urandom), 0);
    reset = 1;
    input_valid = 1;
    input_data = WIDTH'($urandom);
    tick();
    reset = 0;
    input_valid = 0;
    check_idle("abort_state");
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (output_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_output: valid=%0b required 0", output_valid);
      end
    end
    run_problem(1, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 5; p++) begin
      if ($urandom_range(0, 1) == 1 || p == 0) begin
        randomize_all();
        run_problem(1, 1'($urandom), -1);
      end else begin
        for (int i = 0; i < N; i++) x_in[i] = WIDTH'($urandom);
        run_problem(0, 1'($urandom), $urandom_range(0, M));
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_reuse();
    test_extreme();
    test_backpressure();
    test_random_gaps();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
